// File: rtl/ibex_xif_csr_arb_pkg.sv
// Shared types for the XIF/CSR register-bank arbiter: op codes and FSM states.
package ibex_xif_csr_arb_pkg;

    typedef enum logic [1:0] {
        CSR_READ  = 2'd0,
        CSR_WRITE = 2'd1,
        CSR_SET   = 2'd2,
        CSR_CLEAR = 2'd3
    } csr_op_e;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_EXEC = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    localparam int unsigned NumPorts = 2;

endpackage

// File: rtl/ibex_xif_rr_arb2.sv
// Two-way round-robin arbiter; the pointer flips to the other port after every grant.
module ibex_xif_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic ptr_r;

    // Grant selection: a lone requester always wins, a tie is broken by the pointer.
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = ptr_r ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
    end

    // Pointer update: favour the port that was not just served.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= 1'b0;
        end else if (advance) begin
            ptr_r <= gnt[0];
        end
    end

endmodule

// File: rtl/ibex_xif_csr_arbiter.sv
// Shadowed CSR bank shared between the core CSR unit (port 0) and the XIF port (port 1),
// executing atomic read-modify-write ops one at a time with round-robin arbitration.
module ibex_xif_csr_arbiter
    import ibex_xif_csr_arb_pkg::*;
#(
    parameter int unsigned NumCsr     = 4,
    parameter int unsigned Width      = 32,
    parameter bit          ShadowCopy = 1'b1,
    parameter int unsigned AddrW      = $clog2(NumCsr)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [1:0]              req_valid_i,
    output logic [1:0]              req_ready_o,
    input  logic [2*AddrW-1:0]      req_addr_i,
    input  logic [3:0]              req_op_i,
    input  logic [2*Width-1:0]      req_wdata_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic                    rsp_id_o,
    output logic [Width-1:0]        rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic [NumCsr*Width-1:0] csr_q_o,
    output logic                    alert_o
);

    typedef struct packed {
        logic [AddrW-1:0] addr;
        csr_op_e          op;
        logic [Width-1:0] wdata;
    } csr_req_t;

    function automatic logic [Width-1:0] apply_op(input csr_op_e op,
                                                  input logic [Width-1:0] old,
                                                  input logic [Width-1:0] wdata);
        case (op)
            CSR_WRITE: apply_op = wdata;
            CSR_SET:   apply_op = old | wdata;
            CSR_CLEAR: apply_op = old & ~wdata;
            default:   apply_op = old;
        endcase
    endfunction

    arb_state_e                   state_r;
    csr_req_t                     req_r;
    logic                         id_r;
    logic [NumCsr-1:0][Width-1:0] regs_r;
    logic [NumCsr-1:0][Width-1:0] shadow_r;
    logic                         rsp_valid_r;
    logic                         rsp_id_r;
    logic [Width-1:0]             rsp_rdata_r;
    logic                         rsp_err_r;
    logic                         alert_r;

    logic [1:0]       gnt_s;
    logic             accept_s;
    csr_req_t         sel_req_s;
    logic             addr_ok_s;
    logic             int_err_s;
    logic [Width-1:0] old_s;
    logic [Width-1:0] new_s;
    logic             commit_s;

    ibex_xif_rr_arb2 u_rr_arb (
        .clk     (clk_i),
        .rst     (rst_i),
        .req     (req_valid_i),
        .advance (accept_s),
        .gnt     (gnt_s)
    );

    assign req_ready_o = (state_r == ARB_IDLE && !rst_i) ? gnt_s : 2'b00;
    assign accept_s    = |(req_valid_i & req_ready_o);

    // Mux the granted port's request fields for latching on accept.
    always_comb begin
        sel_req_s = '0;
        if (gnt_s[1]) begin
            sel_req_s.addr  = req_addr_i[2*AddrW-1:AddrW];
            sel_req_s.op    = csr_op_e'(req_op_i[3:2]);
            sel_req_s.wdata = req_wdata_i[2*Width-1:Width];
        end else begin
            sel_req_s.addr  = req_addr_i[AddrW-1:0];
            sel_req_s.op    = csr_op_e'(req_op_i[1:0]);
            sel_req_s.wdata = req_wdata_i[Width-1:0];
        end
    end

    // Execute-stage datapath: decode, integrity check and new-value computation.
    always_comb begin
        addr_ok_s = (int'(req_r.addr) < int'(NumCsr));
        old_s     = '0;
        int_err_s = 1'b0;
        if (addr_ok_s) begin
            old_s     = regs_r[req_r.addr];
            int_err_s = ShadowCopy && (old_s != ~shadow_r[req_r.addr]);
        end else begin
            old_s     = '0;
            int_err_s = 1'b0;
        end
        new_s    = apply_op(req_r.op, old_s, req_r.wdata);
        commit_s = (state_r == ARB_EXEC) && addr_ok_s && !int_err_s && (req_r.op != CSR_READ);
    end

    // Control FSM with registered response outputs and the sticky alert.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= ARB_IDLE;
            req_r       <= '0;
            id_r        <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= 1'b0;
            rsp_rdata_r <= '0;
            rsp_err_r   <= 1'b0;
            alert_r     <= 1'b0;
        end else begin
            case (state_r)
                ARB_IDLE: begin
                    if (accept_s) begin
                        req_r   <= sel_req_s;
                        id_r    <= gnt_s[1];
                        state_r <= ARB_EXEC;
                    end
                end
                ARB_EXEC: begin
                    rsp_valid_r <= 1'b1;
                    rsp_id_r    <= id_r;
                    rsp_rdata_r <= old_s;
                    rsp_err_r   <= !addr_ok_s || int_err_s;
                    if (int_err_s) begin
                        alert_r <= 1'b1;
                    end
                    state_r <= ARB_RESP;
                end
                ARB_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= ARB_IDLE;
                    end
                end
                default: state_r <= ARB_IDLE;
            endcase
        end
    end

    // Register bank: commits land at the end of the execute cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            regs_r <= '0;
        end else if (commit_s) begin
            regs_r[req_r.addr] <= new_s;
        end
    end

    if (ShadowCopy) begin : g_shadow
        // Inverted shadow copy, rewritten alongside every committed value.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                shadow_r <= '1;
            end else if (commit_s) begin
                shadow_r[req_r.addr] <= ~new_s;
            end
        end
    end else begin : g_no_shadow
        assign shadow_r = '1;
    end

    assign csr_q_o     = regs_r;
    assign rsp_valid_o = rsp_valid_r;
    assign rsp_id_o    = rsp_id_r;
    assign rsp_rdata_o = rsp_rdata_r;
    assign rsp_err_o   = rsp_err_r;
    assign alert_o     = alert_r;

endmodule

// File: tb/tb_ibex_xif_csr_arbiter.sv
// Directed bench for ibex_xif_csr_arbiter with a 3-entry bank so that address 3 is out of range.
module tb_ibex_xif_csr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [3:0]  req_addr = 4'd0;
    logic [3:0]  req_op = 4'd0;
    logic [63:0] req_wdata = 64'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        rsp_id;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [95:0] csr_q;
    logic        alert;

    int checks = 0;
    int errors = 0;

    ibex_xif_csr_arbiter #(
        .NumCsr     (3),
        .Width      (32),
        .ShadowCopy (1'b1)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_addr_i  (req_addr),
        .req_op_i    (req_op),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_id_o    (rsp_id),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .csr_q_o     (csr_q),
        .alert_o     (alert)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction with rsp_ready held high.
    task automatic txn(input int port, input logic [1:0] addr, input logic [1:0] op,
                       input logic [31:0] wd, input logic [31:0] exp_rd,
                       input logic exp_err, input string tag);
        int   n;
        logic pb;
        pb = (port == 1);
        @(negedge clk);
        req_addr[port*2 +: 2]    = addr;
        req_op[port*2 +: 2]      = op;
        req_wdata[port*32 +: 32] = wd;
        req_valid[port]          = 1'b1;
        #1;
        n = 0;
        while (req_ready == 2'b00 && n < 8) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({tag, "_ready"}, 96'(req_ready), pb ? 96'd2 : 96'd1);
        @(posedge clk);
        #1;
        req_valid[port] = 1'b0;
        chk({tag, "_exec"}, 96'(rsp_valid), 96'd0);
        @(posedge clk);
        #1;
        chk({tag, "_rsp"}, 96'({rsp_valid, rsp_id, rsp_err, rsp_rdata}),
            96'({1'b1, pb, exp_err, exp_rd}));
        @(posedge clk);
        #1;
        chk({tag, "_done"}, 96'(rsp_valid), 96'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_ready", 96'(req_ready), 96'd0);
        chk("rst_rsp", 96'({rsp_valid, rsp_id, rsp_err, rsp_rdata}), 96'd0);
        chk("rst_alert", 96'(alert), 96'd0);
        chk("rst_csr", csr_q, 96'd0);

        // Basic write from port 0
        txn(0, 2'd1, 2'd1, 32'hDEADBEEF, 32'h0, 1'b0, "wr1");
        chk("wr1_csr", csr_q, {32'h0, 32'hDEADBEEF, 32'h0});

        // Set / clear read-modify-write from port 1
        txn(0, 2'd2, 2'd1, 32'h000000F0, 32'h0, 1'b0, "wr2");
        txn(1, 2'd2, 2'd2, 32'h0000000F, 32'h000000F0, 1'b0, "set2");
        txn(1, 2'd2, 2'd3, 32'h000000F0, 32'h000000FF, 1'b0, "clr2");
        chk("rmw_csr", csr_q, {32'h0000000F, 32'hDEADBEEF, 32'h0});

        // Both ports continuously requesting READ addr0: grants alternate 0,1,0,1
        @(negedge clk);
        req_addr  = 4'd0;
        req_op    = 4'd0;
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            int n;
            n = 0;
            #1;
            while (req_ready == 2'b00 && n < 8) begin
                @(negedge clk);
                #1;
                n++;
            end
            chk("alt_gnt", 96'(req_ready), (i % 2 == 0) ? 96'd1 : 96'd2);
            @(posedge clk);
            #1;
            @(posedge clk);
            #1;
            chk("alt_rsp", 96'({rsp_valid, rsp_id, rsp_err, rsp_rdata}),
                96'({1'b1, (i % 2 == 1), 1'b0, 32'h0}));
            @(negedge clk);
        end
        req_valid = 2'b00;
        @(posedge clk);
        #1;

        // Response back-pressure: output held, no new accept until handshake
        rsp_ready = 1'b0;
        @(negedge clk);
        req_addr[3:2] = 2'd1;
        req_op[3:2]   = 2'd0;
        req_valid[1]  = 1'b1;
        #1;
        chk("stall_gnt", 96'(req_ready), 96'd2);
        @(posedge clk);
        #1;
        req_valid[1]     = 1'b0;
        req_addr[1:0]    = 2'd0;
        req_op[1:0]      = 2'd1;
        req_wdata[31:0]  = 32'h00000055;
        req_valid[0]     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("stall_hold", 96'({rsp_valid, rsp_id, rsp_err, rsp_rdata, req_ready}),
                96'({1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 2'b00}));
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_release", 96'({rsp_valid, req_ready}), 96'({1'b0, 2'b01}));
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(posedge clk);
        #1;
        chk("stall_next_rsp", 96'({rsp_valid, rsp_id, rsp_err, rsp_rdata}),
            96'({1'b1, 1'b0, 1'b0, 32'h0}));
        chk("stall_next_csr", csr_q, {32'h0000000F, 32'hDEADBEEF, 32'h00000055});
        @(posedge clk);
        #1;

        // Out-of-range address
        txn(0, 2'd3, 2'd1, 32'h00001111, 32'h0, 1'b1, "badaddr");
        chk("badaddr_csr", csr_q, {32'h0000000F, 32'hDEADBEEF, 32'h00000055});
        chk("badaddr_alert", 96'(alert), 96'd0);

        // Shadow corruption on reg0: write suppressed, alert raised and sticky
        force dut.shadow_r = {~32'h0000000F, ~32'hDEADBEEF, ~32'h00000055 ^ 32'h00000001};
        txn(0, 2'd0, 2'd1, 32'h00001234, 32'h00000055, 1'b1, "fault");
        chk("fault_csr", csr_q, {32'h0000000F, 32'hDEADBEEF, 32'h00000055});
        chk("fault_alert", 96'(alert), 96'd1);
        release dut.shadow_r;
        txn(1, 2'd1, 2'd0, 32'h0, 32'hDEADBEEF, 1'b0, "post_fault_rd");
        chk("alert_sticky", 96'(alert), 96'd1);

        // Reset asserted in EXEC: transaction dropped, bank cleared
        @(negedge clk);
        req_addr[1:0]   = 2'd2;
        req_op[1:0]     = 2'd1;
        req_wdata[31:0] = 32'h0000AAAA;
        req_valid[0]    = 1'b1;
        #1;
        chk("rstexec_gnt", 96'(req_ready), 96'd1);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        rst          = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rstexec_state", 96'({rsp_valid, alert}), 96'd0);
        chk("rstexec_csr", csr_q, 96'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rstexec_norsp", 96'(rsp_valid), 96'd0);
        txn(0, 2'd0, 2'd0, 32'h0, 32'h0, 1'b0, "rd0");
        txn(1, 2'd1, 2'd0, 32'h0, 32'h0, 1'b0, "rd1");
        txn(0, 2'd2, 2'd0, 32'h0, 32'h0, 1'b0, "rd2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
